// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave that transmits a parallel word and captures one
// received frame per chip-select assertion. Operates entirely in the clk domain.
// SPI inputs are oversampled, so clk must run at least 8x faster than spi_clk.
// Optional feature macro: SPI_REG_SLAVE_FRAME_ERR_EN adds the frame_err output.
// This output pulses for a frame whose length is neither zero nor WIDTH.
module spi_reg_slave #(
  parameter int WIDTH = 48,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] memory,
  output logic             rd_ack,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_valid,
  output logic             busy
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
  ,
  output logic             frame_err
`endif
);

  // bit_cnt saturates at WIDTH+1, so it needs room for that value.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Synchronizer stages (s1, s2) and history flops (h) for edge detection.
  logic sclk_s1, sclk_s2, sclk_h;
  logic cs_s1, cs_s2, cs_h;
  logic mosi_s1, mosi_s2, mosi_h;

  // Arming logic: no frame may start until cs_n has been seen high after reset.
  logic [1:0] settle_q;
  logic       armed_q;

  // Datapath registers.
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             first_pend_q;

  // Decoded edges and FSM control strobes.
  logic sclk_lead, sclk_trail;
  logic sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic load, do_sample, do_shift, clr_first, wr_load;

  // Bring the asynchronous SPI pins into the clk domain; reset to idle levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_h  <= CPOL;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      mosi_h  <= 1'b0;
    end else begin
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      mosi_h  <= mosi_s2;
    end
  end

  // Arm once the synchronizer holds real pin values and reports cs_n high.
  // A cs_n held low through reset cannot start a frame until it rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd2 && cs_s2) begin
        armed_q <= 1'b1;
      end
    end
  end

  // The leading edge leaves the CPOL idle level; the trailing edge returns to it.
  assign sclk_lead   = (sclk_s2 != CPOL) && (sclk_h == CPOL);
  assign sclk_trail  = (sclk_s2 == CPOL) && (sclk_h != CPOL);
  assign sample_edge = CPHA ? sclk_trail : sclk_lead;
  assign shift_edge  = CPHA ? sclk_lead  : sclk_trail;
  assign cs_fall     = armed_q && cs_h && !cs_s2;
  assign cs_rise     = !cs_h && cs_s2;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    clr_first = 1'b0;
    wr_load   = 1'b0;
    rd_ack    = 1'b0;
    wr_valid  = 1'b0;
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
    frame_err = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
          rd_ack  = 1'b1;
        end
      end
      ACTIVE: begin
        // Any spi_clk edge seen together with cs_n rising is dropped.
        if (cs_rise) begin
          state_d = DONE;
        end else begin
          do_sample = sample_edge;
          if (shift_edge) begin
            // With CPHA=1 the first leading edge only presents the already-loaded MSB.
            if (first_pend_q) begin
              clr_first = 1'b1;
            end else begin
              do_shift = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bit_cnt_q == CNT_FULL) begin
          wr_load  = 1'b1;
          wr_valid = 1'b1;
        end
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
        frame_err = (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL);
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift registers, bit counter and the received-word holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      first_pend_q <= 1'b0;
      wr_data      <= '0;
    end else begin
      if (load) begin
        tx_q         <= memory;
        rx_q         <= '0;
        bit_cnt_q    <= '0;
        first_pend_q <= CPHA;
      end else begin
        if (do_sample) begin
          rx_q <= {rx_q[WIDTH-2:0], mosi_h};
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        if (do_shift) begin
          tx_q <= {tx_q[WIDTH-2:0], 1'b0};
        end
        if (clr_first) begin
          first_pend_q <= 1'b0;
        end
      end
      if (wr_load) begin
        wr_data <= rx_q;
      end
    end
  end

  assign miso = tx_q[WIDTH-1];
  assign busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives four spi_reg_slave instances, one per SPI mode, as
// an SPI master. It checks read data, write data, pulse counts and reset aborts.
module tb_spi_reg_slave;

  localparam int W = 48;
  localparam time HALF = 80ns;
  localparam int EVT_MEM = 0;
  localparam int EVT_RST = 1;

  localparam logic [47:0] MEM_A = 48'h01AA55000F43;
  localparam logic [47:0] TX_A  = 48'h123456789ABC;
  localparam logic [47:0] MEM_B = 48'hA5A50F0F3C3C;
  localparam logic [47:0] MEM_C = 48'h5A5AF0F0C3C3;
  localparam logic [47:0] TX_B  = 48'hCAFEF00DBEEF;
  localparam logic [63:0] TX_47 = 64'h0000_2AAA_5555_1234;
  localparam logic [63:0] TX_49 = 64'h0001_F0E1_D2C3_B4A5;

  logic         clk;
  logic         reset;
  logic [3:0]   sclk;
  logic [3:0]   cs_n;
  logic [3:0]   mosi;
  logic [3:0]   miso;
  logic [3:0]   rd_ack;
  logic [3:0]   wr_valid;
  logic [3:0]   busy;
  logic [W-1:0] memory  [4];
  logic [W-1:0] wr_data [4];
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
  logic [3:0]   frame_err;
  int           fe_cnt [4];
`endif

  int rd_cnt [4];
  int wr_cnt [4];
  int n_checks;
  int n_pass;

  // Instance g runs SPI mode g: CPOL = g[1], CPHA = g[0].
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_reg_slave #(
      .WIDTH(W),
      .CPOL (g / 2),
      .CPHA (g % 2)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .spi_clk  (sclk[g]),
      .cs_n     (cs_n[g]),
      .mosi     (mosi[g]),
      .miso     (miso[g]),
      .memory   (memory[g]),
      .rd_ack   (rd_ack[g]),
      .wr_data  (wr_data[g]),
      .wr_valid (wr_valid[g]),
      .busy     (busy[g])
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      ,
      .frame_err(frame_err[g])
`endif
    );
  end

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5ns clk = ~clk;
  end

  // Pulse counters, sampled on the falling edge away from register updates.
  initial begin
    for (int g = 0; g < 4; g++) begin
      rd_cnt[g] = 0;
      wr_cnt[g] = 0;
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      fe_cnt[g] = 0;
`endif
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (rd_ack[g])   rd_cnt[g]++;
        if (wr_valid[g]) wr_cnt[g]++;
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
        if (frame_err[g]) fe_cnt[g]++;
`endif
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One SPI master transfer of nbits on instance m. An optional event at bit
  // evt_at either swaps the memory word or pulses reset mid-frame.
  task automatic spi_xfer(input int m, input int nbits, input logic [63:0] tx,
                          input int evt_at, input int evt_kind, input logic [47:0] new_mem,
                          output logic [63:0] rx, output logic busy_mid);
    logic cpol;
    logic cpha;
    cpol = 1'((m >> 1) & 1);
    cpha = 1'(m & 1);
    rx = '0;
    busy_mid = 1'b0;
    cs_n[m] = 1'b0;
    if (!cpha) mosi[m] = tx[nbits-1];
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == evt_at) begin
        if (evt_kind == EVT_MEM) begin
          memory[m] = new_mem;
        end else begin
          @(posedge clk);
          #1ns reset = 1'b1;
          repeat (3) @(posedge clk);
          #1ns reset = 1'b0;
        end
      end
      if (i == nbits / 2) busy_mid = busy[m];
      sclk[m] = ~cpol;
      if (cpha) mosi[m] = tx[nbits-1-i];
      else      rx = {rx[62:0], miso[m]};
      #(HALF);
      sclk[m] = cpol;
      if (cpha) rx = {rx[62:0], miso[m]};
      else if (i < nbits - 1) mosi[m] = tx[nbits-2-i];
      #(HALF);
    end
    cs_n[m] = 1'b1;
    mosi[m] = 1'b0;
    #200ns;
  endtask

  // Directed stimulus per mode, then the reset-abort sequence, then the report.
  initial begin
    logic [63:0] rx;
    logic        bm;
    int          rd0, wr0;
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
    int          fe0;
`endif
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    sclk     = 4'b1100;
    cs_n     = 4'b1111;
    mosi     = 4'b0000;
    for (int g = 0; g < 4; g++) memory[g] = '0;
    repeat (5) @(posedge clk);
    #1ns reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      check_eq($sformatf("m%0d_reset_miso", m), 64'(miso[m]), 64'd0);
      check_eq($sformatf("m%0d_reset_busy", m), 64'(busy[m]), 64'd0);
      check_eq($sformatf("m%0d_reset_wr_data", m), 64'(wr_data[m]), 64'd0);
      check_eq($sformatf("m%0d_reset_rd_cnt", m), 64'(rd_cnt[m]), 64'd0);
      check_eq($sformatf("m%0d_reset_wr_cnt", m), 64'(wr_cnt[m]), 64'd0);
    end

    for (int m = 0; m < 4; m++) begin
      // Full-duplex 48-bit frame: read MEM_A, write TX_A.
      @(posedge clk);
      #1ns memory[m] = MEM_A;
      rd0 = rd_cnt[m];
      wr0 = wr_cnt[m];
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      fe0 = fe_cnt[m];
`endif
      spi_xfer(m, 48, 64'(TX_A), -1, EVT_MEM, '0, rx, bm);
      check_eq($sformatf("m%0d_read48", m), rx, 64'(MEM_A));
      check_eq($sformatf("m%0d_wr_data48", m), 64'(wr_data[m]), 64'(TX_A));
      check_eq($sformatf("m%0d_wr_pulses48", m), 64'(wr_cnt[m] - wr0), 64'd1);
      check_eq($sformatf("m%0d_rd_pulses48", m), 64'(rd_cnt[m] - rd0), 64'd1);
      check_eq($sformatf("m%0d_busy_mid", m), 64'(bm), 64'd1);
      check_eq($sformatf("m%0d_busy_after", m), 64'(busy[m]), 64'd0);
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      check_eq($sformatf("m%0d_ferr48", m), 64'(fe_cnt[m] - fe0), 64'd0);
`endif

      // Short frame: 47 bits, must be discarded.
      rd0 = rd_cnt[m];
      wr0 = wr_cnt[m];
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      fe0 = fe_cnt[m];
`endif
      spi_xfer(m, 47, TX_47, -1, EVT_MEM, '0, rx, bm);
      check_eq($sformatf("m%0d_read47", m), rx, 64'(MEM_A) >> 1);
      check_eq($sformatf("m%0d_wr_data47", m), 64'(wr_data[m]), 64'(TX_A));
      check_eq($sformatf("m%0d_wr_pulses47", m), 64'(wr_cnt[m] - wr0), 64'd0);
      check_eq($sformatf("m%0d_rd_pulses47", m), 64'(rd_cnt[m] - rd0), 64'd1);
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      check_eq($sformatf("m%0d_ferr47", m), 64'(fe_cnt[m] - fe0), 64'd1);
`endif

      // Long frame: 49 bits, 49th bit transmitted as 0, frame discarded.
      wr0 = wr_cnt[m];
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      fe0 = fe_cnt[m];
`endif
      spi_xfer(m, 49, TX_49, -1, EVT_MEM, '0, rx, bm);
      check_eq($sformatf("m%0d_read49", m), rx, 64'(MEM_A) << 1);
      check_eq($sformatf("m%0d_wr_data49", m), 64'(wr_data[m]), 64'(TX_A));
      check_eq($sformatf("m%0d_wr_pulses49", m), 64'(wr_cnt[m] - wr0), 64'd0);
`ifdef SPI_REG_SLAVE_FRAME_ERR_EN
      check_eq($sformatf("m%0d_ferr49", m), 64'(fe_cnt[m] - fe0), 64'd1);
`endif

      // memory changes at bit 10; the captured word must still be sent.
      @(posedge clk);
      #1ns memory[m] = MEM_B;
      wr0 = wr_cnt[m];
      spi_xfer(m, 48, 64'(TX_B), 10, EVT_MEM, MEM_C, rx, bm);
      check_eq($sformatf("m%0d_read_memchg", m), rx, 64'(MEM_B));
      check_eq($sformatf("m%0d_wr_data_memchg", m), 64'(wr_data[m]), 64'(TX_B));
      check_eq($sformatf("m%0d_wr_pulses_memchg", m), 64'(wr_cnt[m] - wr0), 64'd1);
    end

    for (int m = 0; m < 4; m++) begin
      // Reset at bit 20 with cs_n held low: the frame is aborted silently.
      @(posedge clk);
      #1ns memory[m] = MEM_A;
      rd0 = rd_cnt[m];
      wr0 = wr_cnt[m];
      spi_xfer(m, 48, 64'(TX_B), 20, EVT_RST, '0, rx, bm);
      check_eq($sformatf("m%0d_abort_wr_pulses", m), 64'(wr_cnt[m] - wr0), 64'd0);
      check_eq($sformatf("m%0d_abort_rd_pulses", m), 64'(rd_cnt[m] - rd0), 64'd1);
      check_eq($sformatf("m%0d_abort_wr_data", m), 64'(wr_data[m]), 64'd0);
      check_eq($sformatf("m%0d_abort_busy_mid", m), 64'(bm), 64'd0);

      // The next normal frame must be correct.
      rd0 = rd_cnt[m];
      wr0 = wr_cnt[m];
      spi_xfer(m, 48, 64'(TX_A), -1, EVT_MEM, '0, rx, bm);
      check_eq($sformatf("m%0d_post_read", m), rx, 64'(MEM_A));
      check_eq($sformatf("m%0d_post_wr_data", m), 64'(wr_data[m]), 64'(TX_A));
      check_eq($sformatf("m%0d_post_wr_pulses", m), 64'(wr_cnt[m] - wr0), 64'd1);
      check_eq($sformatf("m%0d_post_rd_pulses", m), 64'(rd_cnt[m] - rd0), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
